// File: rtl/cla_slice_sequencer.sv
// ============================================================================
//  Module  : cla_slice_sequencer
//  Brief   : Multi-cycle add/subtract that time-shares one external CLA slice,
//            processing one slice per cycle, LSB slice first.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_slice_sequencer #(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_sum,
    output logic               out_cout,
    output logic               out_ovf,
    output logic [SLICE_W-1:0] slc_a,
    output logic [SLICE_W-1:0] slc_b,
    output logic               slc_cin,
    input  logic [SLICE_W-1:0] slc_sum,
    input  logic               slc_cout
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NSLICE - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]                     r_state;
    logic [1:0]                     w_state_next;
    logic [IDX_W-1:0]               r_idx;
    logic                           r_carry;
    logic [NSLICE-1:0][SLICE_W-1:0] r_a;
    logic [NSLICE-1:0][SLICE_W-1:0] r_b;
    logic [NSLICE-1:0][SLICE_W-1:0] r_sum;
    logic [NSLICE-1:0][SLICE_W-1:0] w_sum_next;
    logic                           w_ovf;
    logic [DATA_W-1:0]              r_out_sum;
    logic                           r_out_cout;
    logic                           r_out_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)             w_state_next = c_RUN;
            c_RUN:   if (r_idx == c_LAST_IDX)  w_state_next = c_DONE;
            c_DONE:  if (out_ready)            w_state_next = c_IDLE;
            default:                           w_state_next = c_IDLE;
        endcase
    end

    // Output logic; the slice bus is quiet outside RUN
    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
        slc_a     = '0;
        slc_b     = '0;
        slc_cin   = 1'b0;
        if (r_state == c_RUN) begin
            slc_a   = r_a[r_idx];
            slc_b   = r_b[r_idx];
            slc_cin = r_carry;
        end
    end

    // Full sum including the slice currently on the bus, used on the final slice
    always_comb begin
        w_sum_next        = r_sum;
        w_sum_next[r_idx] = slc_sum;
        w_ovf = (r_a[NSLICE-1][SLICE_W-1] == r_b[NSLICE-1][SLICE_W-1]) &&
                (w_sum_next[NSLICE-1][SLICE_W-1] != r_a[NSLICE-1][SLICE_W-1]);
    end

    // Result registers are separate so the published result holds through the next RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
            r_out_ovf  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_carry <= in_sub;
                        r_idx   <= '0;
                    end
                end
                c_RUN: begin
                    r_sum[r_idx] <= slc_sum;
                    r_carry      <= slc_cout;
                    if (r_idx == c_LAST_IDX) begin
                        r_out_sum  <= w_sum_next;
                        r_out_cout <= slc_cout;
                        r_out_ovf  <= w_ovf;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = r_out_sum;
    assign out_cout = r_out_cout;
    assign out_ovf  = r_out_ovf;

endmodule

`default_nettype wire
